// File: rtl/ppg_pkg.sv
// ppg_pkg: shared definitions for the PPG boxcar filter.
//   DATA_W              width of one channel sample
//   RED_HI..IR_LO       bit slices of the packed 36-bit red/IR sample
//   state_t             filter FSM states
package ppg_pkg;

  localparam int DATA_W = 18;

  localparam int RED_HI = 2*DATA_W - 1;  // 35
  localparam int RED_LO = DATA_W;        // 18
  localparam int IR_HI  = DATA_W - 1;    // 17
  localparam int IR_LO  = 0;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ppg_chan_acc.sv
// ppg_chan_acc: running window-sum accumulator for one channel.
// Ports:
//   clk       system clock
//   clear     synchronous clear of the accumulator
//   update    load sum_next into the accumulator
//   add_val   value entering the window
//   sub_val   value leaving the window
//   sub_en    subtract sub_val (window already full)
//   sum_next  window sum including this update
//   avg_next  sum_next >> LOG2_DEPTH, truncated
module ppg_chan_acc #(
  parameter int DATA_W     = ppg_pkg::DATA_W,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         update,
  input  logic [DATA_W-1:0]            add_val,
  input  logic [DATA_W-1:0]            sub_val,
  input  logic                         sub_en,
  output logic [DATA_W+LOG2_DEPTH-1:0] sum_next,
  output logic [DATA_W-1:0]            avg_next
);

  localparam int ACC_W = DATA_W + LOG2_DEPTH;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_ext;
  logic [ACC_W-1:0] sub_ext;

  assign add_ext = {{LOG2_DEPTH{1'b0}}, add_val};
  assign sub_ext = sub_en ? {{LOG2_DEPTH{1'b0}}, sub_val} : '0;

  // acc + add may transiently exceed ACC_W bits, but the final window sum
  // always fits, so modular arithmetic yields the exact result.
  assign sum_next = acc + add_ext - sub_ext;
  assign avg_next = sum_next[ACC_W-1:LOG2_DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      acc <= '0;
    end else if (update) begin
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/ppg_boxcar_filter.sv
// ppg_boxcar_filter: moving average over the last 2^LOG2_DEPTH samples,
// applied independently to the red and IR channels of a packed sample.
// Ports:
//   clk            system clock
//   rst_n          synchronous reset, active low
//   sample_in      packed sample {red, ir}, unsigned
//   sample_in_de   single-cycle strobe, sample_in valid
//   flush          synchronous clear of the window
//   sample_out     packed averaged sample {red, ir}
//   sample_out_de  single-cycle strobe, sample_out valid
//   window_full    high while the window holds DEPTH samples
module ppg_boxcar_filter #(
  parameter int DATA_W     = ppg_pkg::DATA_W,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*DATA_W-1:0] sample_in,
  input  logic                sample_in_de,
  input  logic                flush,
  output logic [2*DATA_W-1:0] sample_out,
  output logic                sample_out_de,
  output logic                window_full
);

  import ppg_pkg::*;

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] LAST = LOG2_DEPTH'(DEPTH - 1);

  state_t state, state_next;

  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] fill_cnt;
  logic [2*DATA_W-1:0]   sample_buf [DEPTH];
  logic [2*DATA_W-1:0]   old_sample;

  logic clear;
  logic accept;
  logic emit;

  logic [DATA_W+LOG2_DEPTH-1:0] red_sum, ir_sum;
  logic [DATA_W-1:0]            red_avg, ir_avg;
  logic                         sums_unused;

  assign clear      = !rst_n || flush;
  assign accept     = sample_in_de && !clear;
  assign emit       = accept && ((state == RUN) || (fill_cnt == LAST));
  assign old_sample = sample_buf[wr_ptr];

  assign window_full = (state == RUN);

  always_comb begin
    state_next = state;
    if (accept && (state == FILL) && (fill_cnt == LAST)) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // fill_cnt wraps to 0 on entering RUN; it is only consulted in FILL.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (state == FILL) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  // Not reset: FILL never reads an entry it has not written since clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_buf[wr_ptr] <= sample_in;
    end
  end

  ppg_chan_acc #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_red_acc (
    .clk      (clk),
    .clear    (clear),
    .update   (accept),
    .add_val  (sample_in[RED_HI:RED_LO]),
    .sub_val  (old_sample[RED_HI:RED_LO]),
    .sub_en   (state == RUN),
    .sum_next (red_sum),
    .avg_next (red_avg)
  );

  ppg_chan_acc #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ir_acc (
    .clk      (clk),
    .clear    (clear),
    .update   (accept),
    .add_val  (sample_in[IR_HI:IR_LO]),
    .sub_val  (old_sample[IR_HI:IR_LO]),
    .sub_en   (state == RUN),
    .sum_next (ir_sum),
    .avg_next (ir_avg)
  );

  // Full window sums are only needed for debug observation.
  assign sums_unused = ^{red_sum, ir_sum};

  // flush leaves sample_out holding its last value; only reset zeroes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_out    <= '0;
      sample_out_de <= 1'b0;
    end else begin
      sample_out_de <= emit;
      if (emit) begin
        sample_out <= {red_avg, ir_avg};
      end
    end
  end

endmodule
